// File: rtl/noc_arb_pkg.sv
// Shared definitions for controllers that share one router inport among
// several sources: FSM state type and field-width helpers.
package noc_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_e;

    // Width of a VC number field able to hold 0..no_vc.
    function automatic int vc_width(input int no_vc);
        return $clog2(no_vc + 1);
    endfunction

    // Width of a packet-length field (in flits) able to hold 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Width of a phit down-counter covering a full maximum-length packet.
    function automatic int rem_width(input int max_len, input int flit_size);
        return $clog2(max_len * flit_size + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority picker: returns the first requester found scanning
// upward from the one after last_grant, wrapping around.
module rr_priority_picker #(
    parameter int no_requesters = 4
) (
    input  logic [no_requesters-1:0]         req,
    input  logic [$clog2(no_requesters)-1:0] last_grant,
    output logic                             found,
    output logic [$clog2(no_requesters)-1:0] winner
);

    localparam int GW = $clog2(no_requesters);

    // Scan from the farthest position back to the nearest so that the
    // nearest requester after last_grant is the one left standing.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default at the top of a combinational
        // block so no path leaves it unassigned and no latch is inferred.
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = no_requesters; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % no_requesters;
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/local_inject_arbiter.sv
// Packet-level round-robin arbiter sharing the router's local injection
// inport. Control is registered; the granted source's phits pass through a
// pure combinational mux.
module local_inject_arbiter
    import noc_arb_pkg::*;
#(
    parameter int no_requesters     = 4,
    parameter int phit_size         = 16,
    parameter int flit_size         = 1,
    parameter int no_vc             = 13,
    parameter int max_packet_length = 16
) (
    input  logic                                                      clk,
    input  logic                                                      full_reset_n,
    input  logic                                                      active,
    input  logic [no_requesters-1:0][phit_size-1:0]                   req_data_array,
    input  logic [no_requesters-1:0]                                  req_sent_req,
    input  logic [no_requesters-1:0]                                  req_new,
    input  logic [no_requesters-1:0][vc_width(no_vc)-1:0]             req_vc_no,
    input  logic [no_requesters-1:0][len_width(max_packet_length)-1:0] req_length,
    output logic [no_requesters-1:0]                                  req_ready,
    output logic [phit_size-1:0]                                      out_data,
    output logic                                                      out_sent_req,
    output logic                                                      out_new,
    output logic [vc_width(no_vc)-1:0]                                out_vc_no,
    input  logic                                                      ready_in,
    output logic [$clog2(no_requesters)-1:0]                          grant_id,
    output logic                                                      busy,
    output logic [31:0]                                               packet_count,
    output logic                                                      protocol_error
);

    localparam int GW  = $clog2(no_requesters);
    localparam int VCW = vc_width(no_vc);
    localparam int LW  = len_width(max_packet_length);
    localparam int RW  = rem_width(max_packet_length, flit_size);

    arb_state_e      r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last_grant;
    logic [VCW-1:0]  r_vc;
    logic [RW-1:0]   r_remaining;
    logic [31:0]     r_packet_count;
    logic            r_error;
    logic            r_first;

    logic [no_requesters-1:0] w_cand;
    logic                     w_found;
    logic [GW-1:0]            w_winner;
    logic [LW-1:0]            w_len;
    logic [RW-1:0]            w_len_eff;
    logic [RW-1:0]            w_rem_init;
    logic                     w_xfer;

    // Only a valid header can win arbitration.
    assign w_cand = req_sent_req & req_new;

    rr_priority_picker #(
        .no_requesters (no_requesters)
    ) u_picker (
        .req        (w_cand),
        .last_grant (r_last_grant),
        .found      (w_found),
        .winner     (w_winner)
    );

    // A zero length field still carries one flit.
    assign w_len      = req_length[w_winner];
    assign w_len_eff  = (w_len == '0) ? RW'(1) : RW'(w_len);
    assign w_rem_init = RW'(int'(w_len_eff) * flit_size);

    // Forward the granted source and route ready back to it alone; nothing
    // moves while idle.
    always_comb begin
        out_data     = '0;
        out_sent_req = 1'b0;
        out_new      = 1'b0;
        req_ready    = '0;
        if (r_state == ST_SEND) begin
            out_data           = req_data_array[r_grant];
            out_sent_req       = req_sent_req[r_grant];
            out_new            = req_new[r_grant];
            req_ready[r_grant] = ready_in;
        end
    end

    assign w_xfer = out_sent_req & ready_in;

    // Grant on a header in IDLE, count phits in SEND, release on the tail.
    always_ff @(posedge clk or negedge full_reset_n) begin
        // NOTE: every control register is cleared by the asynchronous reset;
        // last_grant starts at the top index so source 0 is favoured first.
        if (!full_reset_n) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_last_grant   <= GW'(no_requesters - 1);
            r_vc           <= '0;
            r_remaining    <= '0;
            r_packet_count <= '0;
            r_error        <= 1'b0;
            r_first        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of the others.
            case (r_state)
                ST_IDLE: begin
                    if (active && w_found) begin
                        r_state     <= ST_SEND;
                        r_grant     <= w_winner;
                        r_vc        <= req_vc_no[w_winner];
                        r_remaining <= w_rem_init;
                        r_first     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_first     <= 1'b0;
                        r_remaining <= r_remaining - RW'(1);
                        if (req_new[r_grant] && !r_first) begin
                            r_error <= 1'b1;
                        end
                        if (r_remaining == RW'(1)) begin
                            r_state        <= ST_IDLE;
                            r_packet_count <= r_packet_count + 32'd1;
                            r_last_grant   <= r_grant;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_vc_no      = r_vc;
    assign grant_id       = r_grant;
    assign busy           = (r_state == ST_SEND);
    assign packet_count   = r_packet_count;
    assign protocol_error = r_error;

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Self-checking bench for local_inject_arbiter: a behavioural packet model
// predicts every output each cycle; scenario tasks add targeted checks.
module tb_local_inject_arbiter;

    localparam int N   = 4;
    localparam int PW  = 16;
    localparam int VCW = 4;
    localparam int LW  = 5;
    localparam int GW  = 2;
    localparam int FS  = 1;

    logic clk          = 1'b0;
    logic full_reset_n = 1'b0;
    logic active       = 1'b0;
    logic ready_in     = 1'b0;
    logic [N-1:0][PW-1:0]  req_data_array = '0;
    logic [N-1:0]          req_sent_req   = '0;
    logic [N-1:0]          req_new        = '0;
    logic [N-1:0][VCW-1:0] req_vc_no      = '0;
    logic [N-1:0][LW-1:0]  req_length     = '0;

    logic [N-1:0]   req_ready;
    logic [PW-1:0]  out_data;
    logic           out_sent_req, out_new, busy, protocol_error;
    logic [VCW-1:0] out_vc_no;
    logic [GW-1:0]  grant_id;
    logic [31:0]    packet_count;

    // Second instance with two phits per flit, sharing all inputs.
    logic [N-1:0]   d2_req_ready;
    logic [PW-1:0]  d2_out_data;
    logic           d2_out_sent_req, d2_out_new, d2_busy, d2_protocol_error;
    logic [VCW-1:0] d2_out_vc_no;
    logic [GW-1:0]  d2_grant_id;
    logic [31:0]    d2_packet_count;

    local_inject_arbiter dut (
        .clk(clk), .full_reset_n(full_reset_n), .active(active),
        .req_data_array(req_data_array), .req_sent_req(req_sent_req),
        .req_new(req_new), .req_vc_no(req_vc_no), .req_length(req_length),
        .req_ready(req_ready), .out_data(out_data), .out_sent_req(out_sent_req),
        .out_new(out_new), .out_vc_no(out_vc_no), .ready_in(ready_in),
        .grant_id(grant_id), .busy(busy), .packet_count(packet_count),
        .protocol_error(protocol_error)
    );

    local_inject_arbiter #(.flit_size(2)) dut2 (
        .clk(clk), .full_reset_n(full_reset_n), .active(active),
        .req_data_array(req_data_array), .req_sent_req(req_sent_req),
        .req_new(req_new), .req_vc_no(req_vc_no), .req_length(req_length),
        .req_ready(d2_req_ready), .out_data(d2_out_data), .out_sent_req(d2_out_sent_req),
        .out_new(d2_out_new), .out_vc_no(d2_out_vc_no), .ready_in(ready_in),
        .grant_id(d2_grant_id), .busy(d2_busy), .packet_count(d2_packet_count),
        .protocol_error(d2_protocol_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source behaviour: packets left, length field, phit index, forced stall.
    int s_left[N];
    int s_len[N];
    int s_ph[N];
    int s_stall[N];
    int drop_pct;
    int rdy_mode;
    bit err_inj;
    bit rand_len;

    // Reference model of the arbiter.
    bit          m_busy, m_first, m_err;
    int          m_g, m_gid, m_last, m_rem, m_vc;
    logic [31:0] m_count;

    logic [63:0]  act_vec, exp_vec;
    logic [N-1:0] hs;
    int           xfer_src;
    logic         obs_busy;
    logic [GW-1:0] obs_gid;
    logic [31:0]  obs_count;

    function automatic int eff_len(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic logic [63:0] dut_vec();
        return {2'b00, req_ready, out_data, out_sent_req, out_new, out_vc_no,
                grant_id, busy, packet_count, protocol_error};
    endfunction

    function automatic logic [63:0] model_vec();
        logic [N-1:0]  er;
        logic [PW-1:0] ed;
        logic          es, en;
        er = '0; ed = '0; es = 1'b0; en = 1'b0;
        if (m_busy) begin
            ed       = req_data_array[m_g];
            es       = req_sent_req[m_g];
            en       = req_new[m_g];
            er[m_g]  = ready_in;
        end
        return {2'b00, er, ed, es, en, VCW'(m_vc), GW'(m_gid), m_busy, m_count, m_err};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_first = 0; m_err = 0;
        m_g = 0; m_gid = 0; m_last = N - 1; m_rem = 0; m_vc = 0;
        m_count = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        if (!m_busy) begin
            if (active) begin
                for (int k = 1; k <= N; k++) begin
                    int s;
                    s = (m_last + k) % N;
                    if (req_sent_req[s] && req_new[s]) begin
                        m_busy  = 1;
                        m_first = 1;
                        m_g     = s;
                        m_gid   = s;
                        m_vc    = int'(req_vc_no[s]);
                        m_rem   = eff_len(int'(req_length[s])) * FS;
                        break;
                    end
                end
            end
        end else if (req_sent_req[m_g] && ready_in) begin
            if (req_new[m_g] && !m_first) m_err = 1;
            m_first = 0;
            m_rem   = m_rem - 1;
            if (m_rem == 0) begin
                m_count = m_count + 32'd1;
                m_last  = m_g;
                m_busy  = 0;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_data_array[i] = PW'($urandom);
            req_vc_no[i]      = VCW'($urandom);
            req_length[i]     = LW'(s_len[i]);
            req_sent_req[i]   = (s_left[i] > 0) && (s_stall[i] == 0) &&
                                ($urandom_range(99) >= drop_pct);
            req_new[i]        = (s_ph[i] == 0) || (err_inj && $urandom_range(9) == 0);
        end
    endtask

    // One cycle: observe at the falling edge, step model, let sources react.
    task automatic tick();
        @(negedge clk);
        act_vec   = dut_vec();
        exp_vec   = model_vec();
        hs        = req_sent_req & req_ready;
        obs_busy  = busy;
        obs_gid   = grant_id;
        obs_count = packet_count;
        xfer_src  = -1;
        for (int i = 0; i < N; i++) if (hs[i]) xfer_src = i;
        model_update();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                s_ph[i]++;
                if (s_ph[i] >= eff_len(s_len[i]) * FS) begin
                    s_ph[i] = 0;
                    s_left[i]--;
                    if (rand_len) s_len[i] = $urandom_range(31);
                end
            end
            if (s_stall[i] > 0) s_stall[i]--;
        end
        case (rdy_mode)
            1:       ready_in = 1'($urandom_range(1));
            2:       ready_in = ~ready_in;
            default: ready_in = 1'b1;
        endcase
        drive_inputs();
    endtask

    task automatic do_reset();
        full_reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_left[i] = 0; s_len[i] = 1; s_ph[i] = 0; s_stall[i] = 0;
        end
        drop_pct = 0; rdy_mode = 0; err_inj = 0; rand_len = 0;
        ready_in = 1'b1;
        active   = 1'b1;
        drive_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        full_reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        full_reset_n = 1'b0;
        active = 1'b1;
        ready_in = 1'b1;
        s_left[0] = 1; s_len[0] = 2; s_ph[0] = 0; s_stall[0] = 0;
        drive_inputs();
        #13;
        checks++;
        if (dut_vec() !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", dut_vec());
        end
        do_reset();
        tick();
        checks++;
        if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", act_vec, exp_vec);
        end
    endtask

    task automatic test_single_packet();
        int nx;
        do_reset();
        s_left[0] = 1; s_len[0] = 3;
        drive_inputs();
        nx = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL single_cyc%0d got=%h want=%h", c, act_vec, exp_vec);
            end
            if (xfer_src == 0) begin
                nx++;
                checks++;
                if (c < 1 || c > 3) begin
                    errors++;
                    $display("FAIL single_xfer_cycle got=%0d want=1..3", c);
                end
            end
            if (c == 4) begin
                checks++;
                if (obs_count !== 32'd1 || obs_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_done count=%0d busy=%b want 1/0", obs_count, obs_busy);
                end
            end
        end
        checks++;
        if (nx != 3) begin
            errors++;
            $display("FAIL single_xfers got=%0d want=3", nx);
        end
    endtask

    task automatic test_simultaneous();
        int order[$];
        int when[$];
        int want_o[3];
        int want_c[3];
        want_o = '{0, 1, 2};
        want_c = '{1, 3, 5};
        do_reset();
        for (int i = 0; i < 3; i++) begin s_left[i] = 1; s_len[i] = 1; end
        drive_inputs();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL simul_cyc%0d got=%h want=%h", c, act_vec, exp_vec);
            end
            if (xfer_src >= 0) begin order.push_back(xfer_src); when.push_back(c); end
        end
        checks++;
        if (order.size() != 3) begin
            errors++;
            $display("FAIL simul_count got=%0d want=3", order.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (order[k] != want_o[k] || when[k] != want_c[k]) begin
                    errors++;
                    $display("FAIL simul_order%0d got src%0d@%0d want src%0d@%0d",
                             k, order[k], when[k], want_o[k], want_c[k]);
                end
            end
        end
    endtask

    task automatic test_hold_grant();
        int n1;
        bit done;
        do_reset();
        s_left[1] = 1; s_len[1] = 4;
        rdy_mode = 2;
        drive_inputs();
        tick();
        s_left[0] = 1; s_len[0] = 2;
        s_left[3] = 1; s_len[3] = 1;
        drive_inputs();
        n1 = 0;
        done = 0;
        for (int c = 1; c < 30; c++) begin
            if (c == 3) begin s_stall[1] = 2; drive_inputs(); end
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL hold_cyc%0d got=%h want=%h", c, act_vec, exp_vec);
            end
            if (xfer_src == 1) n1++;
            if (obs_count != 0) done = 1;
            if (!done) begin
                checks++;
                if (obs_busy !== 1'b1 || obs_gid !== 2'd1 || (act_vec[61:58] & 4'b1101) != 4'b0) begin
                    errors++;
                    $display("FAIL hold_grant cyc%0d busy=%b gid=%0d ready=%b want 1/1/only-src1",
                             c, obs_busy, obs_gid, act_vec[61:58]);
                end
            end
        end
        checks++;
        if (n1 != 4 || obs_count !== 32'd3) begin
            errors++;
            $display("FAIL hold_totals src1_xfers=%0d pkts=%0d want 4/3", n1, obs_count);
        end
    endtask

    task automatic test_zero_len_fs2();
        int n2, n1;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_sent_req[i] = 1'b0; req_new[i] = 1'b0; req_length[i] = '0;
        end
        req_sent_req[0] = 1'b1;
        req_new[0]      = 1'b1;
        n2 = 0;
        n1 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (d2_out_sent_req && ready_in) n2++;
            if (out_sent_req && ready_in) n1++;
            if (c == 1 || c == 3 || c == 7) begin
                checks++;
                if (d2_protocol_error !== (c != 1)) begin
                    errors++;
                    $display("FAIL zlen_error cyc%0d got=%b want=%b", c, d2_protocol_error, c != 1);
                end
            end
            @(posedge clk);
            #1;
            if (c == 2) begin req_sent_req = '0; req_new = '0; end
        end
        checks++;
        if (n2 != 2 || d2_packet_count !== 32'd1 || d2_busy !== 1'b0) begin
            errors++;
            $display("FAIL zlen_fs2 xfers=%0d pkts=%0d busy=%b want 2/1/0", n2, d2_packet_count, d2_busy);
        end
        checks++;
        if (n1 != 1) begin
            errors++;
            $display("FAIL zlen_fs1 xfers=%0d want=1", n1);
        end
    endtask

    task automatic test_active_drop();
        do_reset();
        s_left[0] = 1; s_len[0] = 4;
        drive_inputs();
        tick();
        tick();
        active = 1'b0;
        s_left[3] = 1; s_len[3] = 2;
        drive_inputs();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL active_cyc%0d got=%h want=%h", c, act_vec, exp_vec);
            end
        end
        checks++;
        if (obs_count !== 32'd1 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL active_low pkts=%0d busy=%b want 1/0", obs_count, obs_busy);
        end
        active = 1'b1;
        tick();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL active_rise_early busy=%b want=0", obs_busy);
        end
        tick();
        checks++;
        if (obs_busy !== 1'b1 || obs_gid !== 2'd3) begin
            errors++;
            $display("FAIL active_regrant busy=%b gid=%0d want 1/3", obs_busy, obs_gid);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        s_left[1] = 1; s_len[1] = 1;
        drive_inputs();
        tick();
        tick();
        s_left[0] = 1; s_len[0] = 8;
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL midrst_pre%0d got=%h want=%h", c, act_vec, exp_vec);
            end
        end
        #2;
        full_reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 64'd0 || req_sent_req[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async got=%h want=0", dut_vec());
        end
        for (int i = 0; i < N; i++) begin s_left[i] = 0; s_ph[i] = 0; end
        drive_inputs();
        model_reset();
        @(negedge clk);
        full_reset_n = 1'b1;
        @(posedge clk);
        #1;
        s_left[0] = 1; s_len[0] = 1;
        s_left[2] = 1; s_len[2] = 1;
        drive_inputs();
        tick();
        tick();
        checks++;
        if (act_vec !== exp_vec || xfer_src != 0 || obs_gid !== 2'd0) begin
            errors++;
            $display("FAIL midrst_tie src=%0d gid=%0d want 0/0", xfer_src, obs_gid);
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_len = 1; drop_pct = 20; rdy_mode = 1; err_inj = 1;
        for (int i = 0; i < N; i++) begin s_left[i] = 6; s_len[i] = $urandom_range(31); end
        drive_inputs();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(19) == 0) active = ~active;
            tick();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_cyc%0d got=%h want=%h", c, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_simultaneous();
        test_hold_grant();
        test_zero_len_fs2();
        test_active_drop();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/local_inject_arbiter.md
# local_inject_arbiter

Packet-level round-robin arbiter that shares a router's local injection inport among several on-tile traffic sources, for example a synthetic producer, a trace player and a DMA. It sits between the processing-element-side sources and router inport 0. It grants one requester at a time and holds the grant for a whole packet. It forwards that requester's phits, `vc_no` and `new` flag, and returns the router's `ready` to the granted source only.

## Interface
- `no_requesters`, 4, number of sources sharing the port (2..8).
- `phit_size`, 16, phit width in bits.
- `flit_size`, 1, phits per flit.
- `no_vc`, 13, virtual channels; VC field width is `$clog2(no_vc+1)`.
- `max_packet_length`, 16, maximum packet length in flits; length field width LW is `$clog2(max_packet_length+1)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `full_reset_n`  in  1  asynchronous, active-low reset.
- `active`  in  1  high enables new grants.
- `req_data_array`  in  `[phit_size-1:0] x no_requesters`  source phits.
- `req_sent_req`  in  `no_requesters`  phit valid, per source.
- `req_new`  in  `no_requesters`  marks the first phit of a packet (header).
- `req_vc_no`  in  `VCW x no_requesters`  requested VC, sampled with the header.
- `req_length`  in  `LW x no_requesters`  packet length in flits, sampled with the header.
- `req_ready`  out  `no_requesters`  per-source ready.
- `out_data`  out  `phit_size`  phits to router inport 0.
- `out_sent_req`  out  1  phit valid to the router.
- `out_new`  out  1  header marker to the router.
- `out_vc_no`  out  VCW  latched VC of the current packet.
- `ready_in`  in  1  router inport 0 ready.
- `grant_id`  out  `$clog2(no_requesters)`  current or last grantee.
- `busy`  out  1  high in SEND.
- `packet_count`  out  32  packets completed since reset; wraps.
- `protocol_error`  out  1  sticky error flag.

## Operation
States: IDLE and SEND.

IDLE:
- Candidates are sources with `req_sent_req[i] && req_new[i]`.
- If `active` is high and at least one candidate exists:
  - Pick the first candidate scanning upward from `(last_grant+1) mod no_requesters`.
  - Latch `grant_id`, `out_vc_no = req_vc_no[g]` and `remaining = max(req_length[g],1) * flit_size`.
  - Go to SEND.
- No phit transfers in IDLE. All `req_ready` are low and `out_sent_req` is 0.

SEND (combinational datapath):
- `out_data = req_data_array[g]`.
- `out_sent_req = req_sent_req[g]`.
- `out_new = req_new[g]`.
- `req_ready[g] = ready_in`; all other `req_ready` are 0.

Transfer and counting:
- A transfer is `out_sent_req && ready_in`.
- Each transfer decrements `remaining`.
- A transfer with `remaining==1`:
  - increments `packet_count`,
  - sets `last_grant = g`,
  - returns to IDLE.
- Source deasserting `sent_req` mid-packet: no transfer; `remaining` and the grant hold indefinitely.

Rules and corner cases:
- `active` falling mid-packet: the current packet completes; no new grant until `active` is high.
- `req_new[g]` high on a transfer that is not the packet's first phit: `protocol_error` is set and stays set until reset. Forwarding is unaffected.
- Lengths larger than `max_packet_length` are truncated by the field width. The effective length is the field value; a value of 0 is treated as 1.
- `remaining` width: `$clog2(max_packet_length*flit_size+1)`.
- Reset (asynchronous, any time, including mid-packet) sets:
  - state IDLE,
  - all outputs 0, `out_*` 0,
  - `remaining` 0,
  - `packet_count` 0,
  - `protocol_error` 0,
  - `last_grant = no_requesters-1`, so source 0 has highest priority first.

## Timing
- Grant latency: the header is presented in cycle N (in IDLE). The grant is registered at the edge ending N. The header is forwarded combinationally in N+1 and transfers if `ready_in` is high.
- Back-to-back packets from any source have one IDLE bubble cycle between the tail transfer and the next header transfer.
- Datapath latency is zero cycles once granted (pure mux); only control is registered.
- The tail-transfer edge updates `packet_count`, `last_grant` and state together. `busy` falls in the following cycle.
- Simultaneous requests are resolved in a single cycle by the rotating priority.

## Structure
- Shared package `noc_arb_pkg`:
  - state enum `{IDLE, SEND}`,
  - VCW/LW width helper functions,
  - reusable in other port-sharing controllers.
- One sub-module, `rr_priority_picker`:
  - parameterised by `no_requesters`,
  - inputs: request vector and `last_grant`,
  - outputs: `found` and `winner` index,
  - purely combinational.
- The top level holds the FSM, counters, latches and output mux.

## Test plan
- Single source 0, length 3, `flit_size 1`, `ready_in` high: header in cycle 0, then `out_sent_req` high in cycles 1–3. `packet_count` reads 1 and `busy` reads 0 in cycle 4.
- Sources 0, 1 and 2 all request at once, length 1 each: grant order 0, 1, 2. Each packet is followed by a one-cycle bubble.
- Source 1 granted with length 4; `ready_in` toggles 1,0,1,0 and source 1 drops `sent_req` for 2 cycles: exactly 4 transfers, no other source gets `req_ready`, and the grant holds throughout.
- `req_length` 0 with `flit_size 2`: exactly 2 transfers. `req_new` asserted on the second phit sets `protocol_error`, which stays at 1.
- `active` dropped mid-packet: the packet finishes, a pending source 3 is not granted until `active` returns, and is granted one cycle after.
- `full_reset_n` asserted mid-packet: all outputs 0 immediately (asynchronously). After release, source 0 wins a tie against source 2.
